// File: rtl/idli_sqi_ctrl_m.sv
// Quad-SPI SRAM burst controller: CMD/ADDR/DUMMY/DATA sequencing, one nibble per 2 gck, first nibble 1 cycle after accept.
// Backpressure: a missing write nibble holds SCK high; a full read register holds SCK low until it drains.
module idli_sqi_ctrl_m #(
   parameter int SQI_NUM = 2,
   parameter int LEN_W   = 8,
   parameter int CHIP_W  = (SQI_NUM > 1) ? $clog2(SQI_NUM) : 1
) (
   input  logic                 i_sqi_gck,
   input  logic                 i_sqi_rst_n,
   input  logic                 i_sqi_req_vld,
   output logic                 o_sqi_req_rdy,
   input  logic                 i_sqi_req_wr,
   input  logic [CHIP_W-1:0]    i_sqi_req_chip,
   input  logic [23:0]          i_sqi_req_addr,
   input  logic [LEN_W-1:0]     i_sqi_req_len,
   input  logic [3:0]           i_sqi_wr_data,
   input  logic                 i_sqi_wr_vld,
   output logic                 o_sqi_wr_rdy,
   output logic [3:0]           o_sqi_rd_data,
   output logic                 o_sqi_rd_vld,
   input  logic                 i_sqi_rd_rdy,
   output logic                 o_sqi_err,
   output logic [SQI_NUM-1:0]   o_sqi_sck,
   output logic [SQI_NUM-1:0]   o_sqi_cs,
   input  logic [SQI_NUM*4-1:0] i_sqi_sio,
   output logic [SQI_NUM*4-1:0] o_sqi_sio,
   output logic [SQI_NUM-1:0]   o_sqi_sio_oe
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_GAP
   } state_t;

   localparam logic [CHIP_W:0] CHIP_LIM = (CHIP_W+1)'(SQI_NUM);

   state_t             state_q, nxt_state;
   logic [2:0]         cnt_q, nxt_cnt;
   logic [LEN_W-1:0]   len_q, nxt_len;
   logic               hi_q, nxt_hi;
   logic               wr_q, nxt_wr;
   logic [CHIP_W-1:0]  chip_q, nxt_chip;
   logic [23:0]        sh_q, nxt_sh;
   logic               sck_q, nxt_sck;
   logic               act_q, nxt_act;
   logic [3:0]         sio_q, nxt_sio;
   logic               oe_q, nxt_oe;
   logic [3:0]         rd_dat_q, nxt_rd_dat;
   logic               rd_vld_q, nxt_rd_vld;
   logic               err_q, nxt_err;
   logic [3:0]         rd_sel;
   logic               step;
   logic               go_hi;
   logic               sample;

   always_comb begin
      rd_sel = 4'h0;
      for (int i = 0; i < SQI_NUM; i++) begin
         if (chip_q == CHIP_W'(i)) rd_sel = i_sqi_sio[i*4 +: 4];
      end
   end

   // A write nibble is wanted during the high phase that precedes each data nibble.
   assign o_sqi_wr_rdy  = hi_q && wr_q &&
                          ((state_q == ST_ADDR && cnt_q == 3'd5) ||
                           (state_q == ST_DATA && len_q != '0));
   assign o_sqi_req_rdy = (state_q == ST_IDLE);
   assign o_sqi_rd_data = rd_dat_q;
   assign o_sqi_rd_vld  = rd_vld_q;
   assign o_sqi_err     = err_q;

   always_comb begin
      nxt_state  = state_q;
      nxt_cnt    = cnt_q;
      nxt_len    = len_q;
      nxt_hi     = hi_q;
      nxt_wr     = wr_q;
      nxt_chip   = chip_q;
      nxt_sh     = sh_q;
      nxt_sck    = sck_q;
      nxt_act    = act_q;
      nxt_sio    = sio_q;
      nxt_oe     = oe_q;
      nxt_rd_dat = rd_dat_q;
      nxt_rd_vld = rd_vld_q;
      nxt_err    = 1'b0;
      step       = 1'b0;
      go_hi      = 1'b0;
      sample     = 1'b0;

      if (rd_vld_q && i_sqi_rd_rdy) nxt_rd_vld = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_sqi_req_vld) begin
               if ({1'b0, i_sqi_req_chip} >= CHIP_LIM) begin
                  nxt_err = 1'b1;
               end else begin
                  nxt_state = ST_CMD;
                  nxt_cnt   = 3'd0;
                  nxt_hi    = 1'b0;
                  nxt_wr    = i_sqi_req_wr;
                  nxt_chip  = i_sqi_req_chip;
                  nxt_len   = i_sqi_req_len;
                  nxt_sh    = i_sqi_req_addr;
                  nxt_act   = 1'b1;
                  nxt_sck   = 1'b0;
                  nxt_oe    = 1'b1;
                  nxt_sio   = 4'h0;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == 3'd1) begin
               nxt_state = ST_IDLE;
               nxt_cnt   = 3'd0;
            end else begin
               nxt_cnt = cnt_q + 3'd1;
            end
         end
         default: begin
            if (!hi_q) begin
               // Read data low phase: only sample once the output register has room.
               if (state_q == ST_DATA && !wr_q) begin
                  if (!rd_vld_q || i_sqi_rd_rdy) begin
                     sample = 1'b1;
                     go_hi  = 1'b1;
                  end
               end else begin
                  go_hi = 1'b1;
               end
            end else begin
               case (state_q)
                  ST_CMD: begin
                     if (cnt_q == 3'd0) begin
                        nxt_cnt = 3'd1;
                        nxt_sio = wr_q ? 4'h2 : 4'h3;
                     end else begin
                        nxt_state = ST_ADDR;
                        nxt_cnt   = 3'd0;
                        nxt_sio   = sh_q[23:20];
                     end
                     step = 1'b1;
                  end
                  ST_ADDR: begin
                     if (cnt_q != 3'd5) begin
                        nxt_cnt = cnt_q + 3'd1;
                        nxt_sh  = {sh_q[19:0], 4'h0};
                        nxt_sio = sh_q[19:16];
                        step    = 1'b1;
                     end else if (wr_q) begin
                        if (i_sqi_wr_vld) begin
                           nxt_state = ST_DATA;
                           nxt_sio   = i_sqi_wr_data;
                           step      = 1'b1;
                        end
                     end else begin
                        nxt_state = ST_DUMMY;
                        nxt_cnt   = 3'd0;
                        nxt_oe    = 1'b0;
                        nxt_sio   = 4'h0;
                        step      = 1'b1;
                     end
                  end
                  ST_DUMMY: begin
                     if (cnt_q == 3'd0) begin
                        nxt_cnt = 3'd1;
                     end else begin
                        nxt_state = ST_DATA;
                        nxt_cnt   = 3'd0;
                     end
                     step = 1'b1;
                  end
                  default: begin
                     if (len_q == '0) begin
                        nxt_state = ST_GAP;
                        nxt_cnt   = 3'd0;
                        nxt_act   = 1'b0;
                        nxt_oe    = 1'b0;
                        nxt_sio   = 4'h0;
                        step      = 1'b1;
                     end else if (!wr_q || i_sqi_wr_vld) begin
                        nxt_len = len_q - LEN_W'(1);
                        nxt_sio = wr_q ? i_sqi_wr_data : 4'h0;
                        step    = 1'b1;
                     end
                  end
               endcase
            end
         end
      endcase

      if (step) begin
         nxt_sck = 1'b0;
         nxt_hi  = 1'b0;
      end
      if (go_hi) begin
         nxt_sck = 1'b1;
         nxt_hi  = 1'b1;
      end
      if (sample) begin
         nxt_rd_dat = rd_sel;
         nxt_rd_vld = 1'b1;
      end
   end

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         len_q    <= '0;
         hi_q     <= 1'b0;
         wr_q     <= 1'b0;
         chip_q   <= '0;
         sh_q     <= 24'h0;
         sck_q    <= 1'b0;
         act_q    <= 1'b0;
         sio_q    <= 4'h0;
         oe_q     <= 1'b0;
         rd_dat_q <= 4'h0;
         rd_vld_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= nxt_state;
         cnt_q    <= nxt_cnt;
         len_q    <= nxt_len;
         hi_q     <= nxt_hi;
         wr_q     <= nxt_wr;
         chip_q   <= nxt_chip;
         sh_q     <= nxt_sh;
         sck_q    <= nxt_sck;
         act_q    <= nxt_act;
         sio_q    <= nxt_sio;
         oe_q     <= nxt_oe;
         rd_dat_q <= nxt_rd_dat;
         rd_vld_q <= nxt_rd_vld;
         err_q    <= nxt_err;
      end
   end

   // Only the selected device sees any bus activity.
   for (genvar g = 0; g < SQI_NUM; g++) begin : g_chip
      logic sel;
      assign sel               = (chip_q == CHIP_W'(g));
      assign o_sqi_sck[g]      = sel & sck_q;
      assign o_sqi_cs[g]       = ~(sel & act_q);
      assign o_sqi_sio_oe[g]   = sel & oe_q;
      assign o_sqi_sio[g*4 +: 4] = sel ? sio_q : 4'h0;
   end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: randomized bursts against a nibble-sequence / cycle-count reference model.
module tb_idli_sqi_ctrl_m;
   localparam int NUM = 3;
   localparam int LW  = 8;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_sqi_req_vld = 1'b0;
   logic              o_sqi_req_rdy;
   logic              i_sqi_req_wr = 1'b0;
   logic [CW-1:0]     i_sqi_req_chip = '0;
   logic [23:0]       i_sqi_req_addr = '0;
   logic [LW-1:0]     i_sqi_req_len = '0;
   logic [3:0]        i_sqi_wr_data = '0;
   logic              i_sqi_wr_vld = 1'b0;
   logic              o_sqi_wr_rdy;
   logic [3:0]        o_sqi_rd_data;
   logic              o_sqi_rd_vld;
   logic              i_sqi_rd_rdy = 1'b1;
   logic              o_sqi_err;
   logic [NUM-1:0]    o_sqi_sck;
   logic [NUM-1:0]    o_sqi_cs;
   logic [NUM*4-1:0]  i_sqi_sio = '0;
   logic [NUM*4-1:0]  o_sqi_sio;
   logic [NUM-1:0]    o_sqi_sio_oe;

   always #5 clk = ~clk;

   idli_sqi_ctrl_m #(.SQI_NUM(NUM), .LEN_W(LW), .CHIP_W(CW)) dut (
      .i_sqi_gck      (clk),
      .i_sqi_rst_n    (rst_n),
      .i_sqi_req_vld  (i_sqi_req_vld),
      .o_sqi_req_rdy  (o_sqi_req_rdy),
      .i_sqi_req_wr   (i_sqi_req_wr),
      .i_sqi_req_chip (i_sqi_req_chip),
      .i_sqi_req_addr (i_sqi_req_addr),
      .i_sqi_req_len  (i_sqi_req_len),
      .i_sqi_wr_data  (i_sqi_wr_data),
      .i_sqi_wr_vld   (i_sqi_wr_vld),
      .o_sqi_wr_rdy   (o_sqi_wr_rdy),
      .o_sqi_rd_data  (o_sqi_rd_data),
      .o_sqi_rd_vld   (o_sqi_rd_vld),
      .i_sqi_rd_rdy   (i_sqi_rd_rdy),
      .o_sqi_err      (o_sqi_err),
      .o_sqi_sck      (o_sqi_sck),
      .o_sqi_cs       (o_sqi_cs),
      .i_sqi_sio      (i_sqi_sio),
      .o_sqi_sio      (o_sqi_sio),
      .o_sqi_sio_oe   (o_sqi_sio_oe)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [3:0] dq [256];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill_rand(input int len);
      for (int k = 0; k <= len; k++) dq[k] = 4'($urandom);
   endtask

   task automatic check_idle_bus(input string tag);
      check({tag, "_cs"},  32'(o_sqi_cs), 32'h7);
      check({tag, "_sck"}, 32'(o_sqi_sck), 32'h0);
      check({tag, "_oe"},  32'(o_sqi_sio_oe), 32'h0);
      check({tag, "_sio"}, 32'(o_sqi_sio), 32'h0);
   endtask

   // One burst; dq[] holds the write data to send or the data the device returns.
   task automatic run_txn(input bit wr, input int chip, input logic [23:0] addr, input int len,
                          input int wr_hold, input int rd_hold, input bit rnd, input int abort_cyc);
      int cyc, nrise, ndone, ntot, cs_hi, rdy_cyc, first_rdy, first_vld, hold_left;
      int hi_run, lo_run, max_hi, max_lo, base, exp_cs;
      bit bad_other, bad_gap, bad_err, bad_extra, bad_rdy, done, prev_sck;
      logic [3:0] bus_nib [$];
      bit bus_oe [$];
      logic [3:0] exp_nib;

      ntot = (wr ? 8 : 10) + len + 1;
      base = wr ? 8 : 10;
      cyc = 0; nrise = 0; ndone = 0; cs_hi = -1; rdy_cyc = -1; first_rdy = -1; first_vld = -1;
      hold_left = wr_hold; hi_run = 0; lo_run = 0; max_hi = 0; max_lo = 0;
      bad_other = 0; bad_gap = 0; bad_err = 0; bad_extra = 0; bad_rdy = 0; done = 0; prev_sck = 0;

      i_sqi_req_wr   = wr;
      i_sqi_req_chip = CW'(chip);
      i_sqi_req_addr = addr;
      i_sqi_req_len  = LW'(len);
      i_sqi_req_vld  = 1'b1;
      i_sqi_rd_rdy   = 1'b1;
      check("req_rdy_idle", 32'(o_sqi_req_rdy), 32'h1);

      while (!done) begin
         @(negedge clk);
         cyc++;
         i_sqi_req_vld = 1'b0;
         if (cyc == abort_cyc) begin
            check("cs_before_rst", 32'(o_sqi_cs[chip]), 32'h0);
            rst_n = 1'b0;
            #1;
            check_idle_bus("rst_mid");
            check("rst_mid_wr_rdy", 32'(o_sqi_wr_rdy), 32'h0);
            check("rst_mid_rd_vld", 32'(o_sqi_rd_vld), 32'h0);
            check("rst_mid_err", 32'(o_sqi_err), 32'h0);
            i_sqi_wr_vld = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("rst_rel_req_rdy", 32'(o_sqi_req_rdy), 32'h1);
            check("rst_rel_cs", 32'(o_sqi_cs), 32'h7);
            return;
         end
         if (cyc == 1) check("cs_low_c1", 32'(o_sqi_cs[chip]), 32'h0);

         // bus monitor
         if (o_sqi_sck[chip] && !prev_sck) begin
            bus_nib.push_back(o_sqi_sio[chip*4 +: 4]);
            bus_oe.push_back(o_sqi_sio_oe[chip]);
            nrise++;
         end
         prev_sck = o_sqi_sck[chip];
         if (!o_sqi_cs[chip]) begin
            if (o_sqi_req_rdy) bad_rdy = 1;
            if (o_sqi_sck[chip]) begin hi_run++; lo_run = 0; end
            else begin lo_run++; hi_run = 0; end
            if (hi_run > max_hi) max_hi = hi_run;
            if (lo_run > max_lo) max_lo = lo_run;
         end else begin
            if (nrise > 0 && cs_hi < 0) cs_hi = cyc;
            if (o_sqi_sck[chip] || o_sqi_sio_oe[chip] || o_sqi_sio[chip*4 +: 4] != 4'h0) bad_gap = 1;
         end
         if (cs_hi >= 0 && rdy_cyc < 0 && o_sqi_req_rdy) rdy_cyc = cyc;
         for (int i = 0; i < NUM; i++) begin
            if (i != chip && (!o_sqi_cs[i] || o_sqi_sck[i] || o_sqi_sio_oe[i] ||
                              o_sqi_sio[i*4 +: 4] != 4'h0)) bad_other = 1;
         end
         if (o_sqi_err) bad_err = 1;

         // device model: present read nibble k after 10+k SCK rises
         for (int i = 0; i < NUM; i++) i_sqi_sio[i*4 +: 4] = 4'($urandom);
         if (!wr && nrise >= 10 && nrise - 10 <= len) i_sqi_sio[chip*4 +: 4] = dq[nrise-10];

         // write producer
         i_sqi_wr_vld  = 1'b0;
         i_sqi_wr_data = 4'($urandom);
         if (o_sqi_wr_rdy) begin
            if (first_rdy < 0) first_rdy = cyc;
            if (hold_left > 0) hold_left--;
            else if (!(rnd && $urandom_range(0, 2) == 0)) begin
               if (ndone > len) bad_extra = 1;
               else begin
                  i_sqi_wr_vld  = 1'b1;
                  i_sqi_wr_data = dq[ndone];
                  if (!rnd && wr_hold == 0) check("wr_rdy_cyc", 32'(cyc), 32'(16 + 2*ndone));
                  ndone++;
               end
            end
         end

         // read consumer
         if (o_sqi_rd_vld && first_vld < 0) first_vld = cyc;
         if (rnd) i_sqi_rd_rdy = 1'($urandom_range(0, 1));
         else if (first_vld >= 0 && cyc < first_vld + rd_hold) i_sqi_rd_rdy = 1'b0;
         else i_sqi_rd_rdy = 1'b1;
         if (o_sqi_rd_vld && i_sqi_rd_rdy) begin
            if (wr || ndone > len) bad_extra = 1;
            else begin
               check("rd_dat", 32'(o_sqi_rd_data), 32'(dq[ndone]));
               if (!rnd && rd_hold == 0) check("rd_vld_cyc", 32'(cyc), 32'(22 + 2*ndone));
               ndone++;
            end
         end

         done = (cs_hi >= 0) && o_sqi_req_rdy && (ndone == len + 1);
         if (cyc > 4000) begin
            check("txn_timeout", 32'(cyc), 32'h0);
            done = 1;
         end
      end
      i_sqi_rd_rdy = 1'b1;
      i_sqi_wr_vld = 1'b0;

      check("nibble_count", 32'(nrise), 32'(ntot));
      for (int n = 0; n < ntot && n < bus_nib.size(); n++) begin
         if (n == 0) exp_nib = 4'h0;
         else if (n == 1) exp_nib = wr ? 4'h2 : 4'h3;
         else if (n < 8) exp_nib = 4'((addr >> (4*(7-n))) & 24'hF);
         else if (n >= base) exp_nib = dq[n-base];
         else exp_nib = 4'h0;
         if (wr || n < 8) check("bus_nib", 32'(bus_nib[n]), 32'(exp_nib));
         check("bus_oe", 32'(bus_oe[n]), 32'(wr || n < 8));
      end
      check("other_chips_idle", 32'(bad_other), 32'h0);
      check("gap_quiet", 32'(bad_gap), 32'h0);
      check("no_err", 32'(bad_err), 32'h0);
      check("no_extra_xfer", 32'(bad_extra), 32'h0);
      check("busy_not_rdy", 32'(bad_rdy), 32'h0);
      check("req_rdy_after_gap", 32'(rdy_cyc), 32'(cs_hi + 2));
      if (wr) check("first_wr_rdy", 32'(first_rdy), 32'd16);
      else check("first_rd_vld", 32'(first_vld), 32'd22);
      if (!rnd) begin
         exp_cs = 2*ntot + 1 + (wr ? wr_hold : (rd_hold > 0 ? rd_hold - 1 : 0));
         check("cs_high_cyc", 32'(cs_hi), 32'(exp_cs));
         if (wr) check("sck_hi_max", 32'(max_hi), 32'(1 + wr_hold));
         else check("sck_lo_max", 32'(max_lo), 32'(rd_hold > 1 ? rd_hold : 1));
      end
   endtask

   task automatic bad_req(input int chip);
      bit bad;
      bad = 0;
      i_sqi_req_wr   = 1'($urandom);
      i_sqi_req_chip = CW'(chip);
      i_sqi_req_addr = 24'($urandom);
      i_sqi_req_len  = LW'($urandom_range(0, 7));
      i_sqi_req_vld  = 1'b1;
      check("bad_req_rdy", 32'(o_sqi_req_rdy), 32'h1);
      @(negedge clk);
      i_sqi_req_vld = 1'b0;
      check("err_pulse", 32'(o_sqi_err), 32'h1);
      check("bad_stays_idle", 32'(o_sqi_req_rdy), 32'h1);
      if (o_sqi_cs != 3'h7 || o_sqi_sck != 3'h0) bad = 1;
      @(negedge clk);
      check("err_clear", 32'(o_sqi_err), 32'h0);
      repeat (4) begin
         if (o_sqi_cs != 3'h7 || o_sqi_sck != 3'h0 || o_sqi_sio_oe != 3'h0 || o_sqi_err) bad = 1;
         @(negedge clk);
      end
      check("bad_no_bus", 32'(bad), 32'h0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle_bus("rst");
      check("rst_req_rdy", 32'(o_sqi_req_rdy), 32'h1);
      check("rst_wr_rdy", 32'(o_sqi_wr_rdy), 32'h0);
      check("rst_rd_vld", 32'(o_sqi_rd_vld), 32'h0);
      check("rst_err", 32'(o_sqi_err), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // read chip 1, device returns A,B,C,D
      for (int k = 0; k < 4; k++) dq[k] = 4'(4'hA + k);
      run_txn(1'b0, 1, 24'h012345, 3, 0, 0, 1'b0, 0);
      // write chip 0 to the top address
      dq[0] = 4'h9; dq[1] = 4'h6;
      run_txn(1'b1, 0, 24'hFFFFFF, 1, 0, 0, 1'b0, 0);
      // write stall, read backpressure
      fill_rand(3);
      run_txn(1'b1, 1, 24'($urandom), 3, 5, 0, 1'b0, 0);
      fill_rand(3);
      run_txn(1'b0, 2, 24'($urandom), 3, 0, 6, 1'b0, 0);
      // bad chip index then a normal request
      bad_req(3);
      fill_rand(2);
      run_txn(1'b0, 0, 24'($urandom), 2, 0, 0, 1'b0, 0);
      // reset in cycle 12 of a write, then a fresh read
      fill_rand(7);
      run_txn(1'b1, 1, 24'($urandom), 7, 0, 0, 1'b0, 12);
      fill_rand(4);
      run_txn(1'b0, 0, 24'($urandom), 4, 0, 0, 1'b0, 0);
      // length boundaries
      fill_rand(0);
      run_txn(1'b0, 1, 24'($urandom), 0, 0, 0, 1'b0, 0);
      fill_rand(0);
      run_txn(1'b1, 2, 24'($urandom), 0, 0, 0, 1'b0, 0);
      fill_rand(255);
      run_txn(1'b1, 0, 24'($urandom), 255, 0, 0, 1'b0, 0);
      fill_rand(255);
      run_txn(1'b0, 2, 24'($urandom), 255, 0, 0, 1'b1, 0);
      // random traffic with random stalls
      for (int t = 0; t < 20; t++) begin
         int len;
         len = $urandom_range(0, 20);
         fill_rand(len);
         if (t % 7 == 3) bad_req(3);
         run_txn(1'($urandom_range(0, 1)), $urandom_range(0, NUM-1), 24'($urandom), len, 0, 0, 1'b1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
